// File: rtl/pc_pkg.sv
// Shared constants and next-PC operation encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned JFIELD_W    = 26;
    localparam int unsigned PC_OP_W     = 3;

    typedef enum logic [PC_OP_W-1:0] {
        PC_SEQ  = 3'd0,
        PC_BEQ  = 3'd1,
        PC_BNE  = 3'd2,
        PC_J    = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5,
        PC_JR   = 3'd6,
        PC_RSVD = 3'd7
    } pc_op_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// Control/ALU-facing bundle of the program-counter unit; the unit itself uses the slave side.
interface pc_next_unit_if
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic                 en;
    logic [PC_OP_W-1:0]   pc_op;
    logic                 zero;
    logic [WIDTH-1:0]     imm_ext;
    logic [JFIELD_W-1:0]  jump_target;
    logic [WIDTH-1:0]     jr_addr;

    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     pc_plus4;
    logic [WIDTH-1:0]     next_pc;
    logic                 taken;
    logic [CNT_W-1:0]     ras_count;
    logic                 ras_overflow;
    logic                 ret_underflow;
    logic                 ret_mismatch;

    modport master (
        output en, pc_op, zero, imm_ext, jump_target, jr_addr,
        input  pc, pc_plus4, next_pc, taken, ras_count,
               ras_overflow, ret_underflow, ret_mismatch
    );

    modport slave (
        input  en, pc_op, zero, imm_ext, jump_target, jr_addr,
        output pc, pc_plus4, next_pc, taken, ras_count,
               ras_overflow, ret_underflow, ret_mismatch
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               pushData,
    output logic [WIDTH-1:0]               topData,
    output logic [$clog2(RAS_DEPTH):0]     count,
    output logic                           full,
    output logic                           empty
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] countQ;

    assign full    = (countQ == CNT_W'(RAS_DEPTH));
    assign empty   = (countQ == '0);
    assign count   = countQ;
    // When full, wrPtr already points at the oldest entry, so overwrite falls out naturally.
    assign topData = mem[wrPtr - PTR_W'(1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr  <= '0;
            countQ <= '0;
        end else if (push) begin
            wrPtr <= wrPtr + PTR_W'(1);
            if (!full) begin
                countQ <= countQ + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wrPtr  <= wrPtr - PTR_W'(1);
            countQ <= countQ - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter with branch/jump/call/return selection and a debug-only return-address stack.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic clk,
    input  logic reset,
    pc_next_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;
    localparam int unsigned JLO_W = JFIELD_W + 2;

    logic [WIDTH-1:0] pcQ;
    logic [WIDTH-1:0] pcPlus4;
    logic [WIDTH-1:0] branchTarget;
    logic [WIDTH-1:0] jumpTarget;
    logic [WIDTH-1:0] nextPc;
    logic             taken;
    logic             doPush;
    logic             doPop;
    logic             overflowQ;
    logic             underflowQ;
    logic             mismatchQ;
    logic [WIDTH-1:0] rasTop;
    logic [CNT_W-1:0] rasCount;
    logic             rasFull;
    logic             rasEmpty;
    pc_op_e           op;

    assign op           = pc_op_e'(bus.pc_op);
    assign pcPlus4      = pcQ + WIDTH'(INSTR_BYTES);
    assign branchTarget = pcPlus4 + (bus.imm_ext << 2);
    assign jumpTarget   = {pcPlus4[WIDTH-1:JLO_W], bus.jump_target, 2'b00};

    // Next-PC select; RET follows jr_addr, the stack only observes.
    always_comb begin
        nextPc = pcPlus4;
        taken  = 1'b0;
        doPush = 1'b0;
        doPop  = 1'b0;
        case (op)
            PC_BEQ: begin
                if (bus.zero) begin
                    nextPc = branchTarget;
                    taken  = 1'b1;
                end
            end
            PC_BNE: begin
                if (!bus.zero) begin
                    nextPc = branchTarget;
                    taken  = 1'b1;
                end
            end
            PC_J: begin
                nextPc = jumpTarget;
                taken  = 1'b1;
            end
            PC_CALL: begin
                nextPc = jumpTarget;
                taken  = 1'b1;
                doPush = bus.en;
            end
            PC_RET: begin
                nextPc = bus.jr_addr;
                taken  = 1'b1;
                doPop  = bus.en;
            end
            PC_JR: begin
                nextPc = bus.jr_addr;
                taken  = 1'b1;
            end
            default: begin
                nextPc = pcPlus4;
            end
        endcase
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (reset),
        .push     (doPush),
        .pop      (doPop),
        .pushData (pcPlus4),
        .topData  (rasTop),
        .count    (rasCount),
        .full     (rasFull),
        .empty    (rasEmpty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcQ        <= RESET_VECTOR;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
            mismatchQ  <= 1'b0;
        end else if (bus.en) begin
            pcQ        <= nextPc;
            underflowQ <= doPop && rasEmpty;
            mismatchQ  <= doPop && !rasEmpty && (rasTop != bus.jr_addr);
            if (doPush && rasFull) begin
                overflowQ <= 1'b1;
            end
        end else begin
            underflowQ <= 1'b0;
            mismatchQ  <= 1'b0;
        end
    end

    assign bus.pc            = pcQ;
    assign bus.pc_plus4      = pcPlus4;
    assign bus.next_pc       = nextPc;
    assign bus.taken         = taken;
    assign bus.ras_count     = rasCount;
    assign bus.ras_overflow  = overflowQ;
    assign bus.ret_underflow = underflowQ;
    assign bus.ret_mismatch  = mismatchQ;

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter unit for the single-cycle core; successor to the fixed 32-bit PC/+4/branch-mux block. Computes and registers the next fetch address for sequential, conditional-branch (eq/ne), jump, call, return and register-jump flows, with stall support and a configurable reset vector. A small circular return-address stack (RAS) tracks call/return pairing and flags mismatches, overflow and underflow for debug. Sits between control/ALU (branch condition, zero flag) and instruction memory (fetch address).

## Interface
- WIDTH, 32, address width; legal 32..64.
- RESET_VECTOR, 0, PC value after reset; must be a multiple of 4.
- RAS_DEPTH, 4, return-address stack entries; power of two, 2..16.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  1 = advance PC this cycle; 0 = stall (hold PC, no RAS change).
- pc_op  in  3  next-PC operation (encoding in Operation).
- zero  in  1  ALU zero flag.
- imm_ext  in  WIDTH  sign-extended branch offset in words.
- jump_target  in  26  J-format target field.
- jr_addr  in  WIDTH  register-file value for RET/JR.
- pc  out  WIDTH  registered fetch address.
- pc_plus4  out  WIDTH  pc + 4, combinational.
- next_pc  out  WIDTH  value pc loads at the next enabled edge, combinational.
- taken  out  1  non-sequential target selected, combinational.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  out  1  sticky: a push hit a full RAS.
- ret_underflow  out  1  one-cycle pulse: RET with empty RAS.
- ret_mismatch  out  1  one-cycle pulse: popped entry != jr_addr.

## Operation
- pc_op: 0 SEQ, 1 BEQ, 2 BNE, 3 J, 4 CALL, 5 RET, 6 JR, 7 reserved (= SEQ).
- pc_plus4 = pc + 4; branch target = pc_plus4 + (imm_ext << 2); all arithmetic modulo 2^WIDTH, overflow ignored.
- Jump target = {pc_plus4[WIDTH-1:28], jump_target, 2'b00}.
- next_pc: SEQ → pc_plus4; BEQ → branch target if zero=1 else pc_plus4; BNE → branch target if zero=0 else pc_plus4; J and CALL → jump target; RET and JR → jr_addr (architecturally correct; RAS never redirects fetch).
- taken = 1 whenever next_pc is not pc_plus4 by selection (not by value coincidence).
- CALL with en=1: push pc_plus4. If RAS full, overwrite oldest entry, count stays RAS_DEPTH, set ras_overflow.
- RET with en=1: if count>0, pop top, decrement count, compare with jr_addr, pulse ret_mismatch on inequality; if count=0, no pop, pulse ret_underflow.
- JR never touches the RAS.
- en=0: pc, RAS, count, flags hold; pulses deassert; next_pc/taken still reflect inputs.
- ras_overflow clears only on reset.

## Timing
- Reset (async assert): pc=RESET_VECTOR, ras_count=0, ras_overflow=0, ret_underflow=0, ret_mismatch=0 immediately; RAS contents don't-care.
- pc updates on rising clk when en=1; latency one cycle from pc_op to new pc.
- ret_mismatch/ret_underflow registered: high exactly the cycle after the RET edge, then low unless another RET fires.
- Reset asserted mid-sequence discards any pending push/pop; first edge after deassert with en=1 loads next_pc computed from RESET_VECTOR.
- Call at full + wrap: write pointer wraps modulo RAS_DEPTH; pop reads most recent entry.

## Structure
- Package pc_pkg: pc_op encoding constants (PC_SEQ..PC_JR), INSTR_BYTES=4, J-field width 26.
- Sub-module ras_stack: circular LIFO with push/pop/count/full/empty, parametrised by WIDTH and RAS_DEPTH; overwrite-oldest on full push.
- Top holds PC register, target adders, next-PC select, flag registers.

## Test plan
- Reset with RESET_VECTOR=0x400, SEQ×3 → pc 0x400, 0x404, 0x408, 0x40C; ras_count=0.
- pc=0x100, BEQ, imm_ext=-2, zero=1 → pc=0x0FC, taken=1; same with zero=0 → pc=0x104; BNE inverted.
- pc=0x10000010, J, jump_target=0x0000040 → pc=0x10000100; CALL same → RAS top 0x10000014, count 1.
- RAS_DEPTH=4: 5 CALLs → count 4, ras_overflow=1; 5 RETs with matching jr_addr → 4 pops no mismatch, 5th ret_underflow pulse.
- CALL then RET with jr_addr ≠ pushed value → pc=jr_addr, ret_mismatch high one cycle after edge.
- en=0 during CALL, then reset mid-stall → pc, count unchanged while stalled; reset returns pc=RESET_VECTOR, flags 0.
